// File: rtl/matrix_stream_loader_if.sv
// -----------------------------------------------------------------------------
// matrix_stream_loader_if
// Byte-wide valid/ready element stream that feeds the matrix stream loader.
//   i_data  : stream element (DATA_W bits)
//   i_valid : element valid
//   i_last  : final element of a 32-element frame (qualified by i_valid)
//   o_ready : loader can accept an element this cycle
// Modports: master = stream source, slave = loader.
// -----------------------------------------------------------------------------
interface matrix_stream_loader_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] i_data;
  logic              i_valid;
  logic              i_last;
  logic              o_ready;

  modport master (
    output i_data,
    output i_valid,
    output i_last,
    input  o_ready
  );

  modport slave (
    input  i_data,
    input  i_valid,
    input  i_last,
    output o_ready
  );
endinterface

// File: rtl/matrix_stream_loader.sv
// -----------------------------------------------------------------------------
// matrix_stream_loader
// Assembles one 4x4 A matrix and one 4x4 B matrix from a 32-element stream
// (row-major A, then row-major B), launches the systolic array with a
// one-cycle strobe, then blocks input until the array returns a result or
// the wait times out.
// Ports:
//   i_clk, i_arst   : clock, asynchronous active-high reset
//   stream          : element stream (slave side of matrix_stream_loader_if)
//   o_a, o_b        : assembled matrices, indexed [row][col]
//   o_validInput    : one-cycle launch strobe to the array
//   i_validResult   : array result-valid pulse (only honoured in WAIT)
//   o_busy          : high while launching or waiting
//   o_frameError    : one-cycle pulse when a frame is mis-terminated
//   o_timeout       : one-cycle pulse when a wait is abandoned
// -----------------------------------------------------------------------------
module matrix_stream_loader #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 31
) (
  input  logic                          i_clk,
  input  logic                          i_arst,
  matrix_stream_loader_if.slave         stream,
  output logic [3:0][3:0][DATA_W-1:0]   o_a,
  output logic [3:0][3:0][DATA_W-1:0]   o_b,
  output logic                          o_validInput,
  input  logic                          i_validResult,
  output logic                          o_busy,
  output logic                          o_frameError,
  output logic                          o_timeout
);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_LAUNCH,
    ST_WAIT
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_next;
  logic [4:0] count, count_next;
  logic [7:0] wait_cnt, wait_next;
  logic       frame_err_next;
  logic       timeout_next;
  logic       beat;

  // o_ready is a flop that is high exactly when the state register is LOAD,
  // so a beat can only ever occur in LOAD.
  assign beat = stream.i_valid & stream.o_ready;

  // NOTE: every variable assigned here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next     = state;
    count_next     = count;
    wait_next      = wait_cnt;
    frame_err_next = 1'b0;
    timeout_next   = 1'b0;
    unique case (state)
      ST_LOAD: begin
        if (beat) begin
          if (count == 5'd31 && stream.i_last) begin
            state_next = ST_LAUNCH;
            count_next = '0;
          end else if (count == 5'd31 || stream.i_last) begin
            // Frame ended early or overran its 32 elements: drop it.
            frame_err_next = 1'b1;
            count_next     = '0;
          end else begin
            count_next = count + 5'd1;
          end
        end
      end
      ST_LAUNCH: begin
        state_next = ST_WAIT;
        wait_next  = '0;
      end
      ST_WAIT: begin
        // A result arriving on the terminal count wins over the timeout.
        if (i_validResult) begin
          state_next = ST_LOAD;
        end else if (wait_cnt == WAIT_LAST) begin
          state_next   = ST_LOAD;
          timeout_next = 1'b1;
        end else begin
          wait_next = wait_cnt + 8'd1;
        end
      end
      default: state_next = ST_LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state          <= ST_LOAD;
      count          <= '0;
      wait_cnt       <= '0;
      stream.o_ready <= 1'b1;
      o_validInput   <= 1'b0;
      o_busy         <= 1'b0;
      o_frameError   <= 1'b0;
      o_timeout      <= 1'b0;
    end else begin
      state          <= state_next;
      count          <= count_next;
      wait_cnt       <= wait_next;
      stream.o_ready <= (state_next == ST_LOAD);
      o_validInput   <= (state_next == ST_LAUNCH);
      o_busy         <= (state_next != ST_LOAD);
      o_frameError   <= frame_err_next;
      o_timeout      <= timeout_next;
    end
  end

  // NOTE: the matrix storage is reset because the array sees o_a/o_b
  // directly and they must read as zero out of reset.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      o_a <= '0;
      o_b <= '0;
    end else if (beat) begin
      // count[4] selects A (first 16 elements) or B; low bits give row/col.
      if (!count[4]) begin
        o_a[count[3:2]][count[1:0]] <= stream.i_data;
      end else begin
        o_b[count[3:2]][count[1:0]] <= stream.i_data;
      end
    end
  end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// -----------------------------------------------------------------------------
// tb_matrix_stream_loader
// Self-checking bench for matrix_stream_loader (DATA_W=8, TIMEOUT=31).
// Per-cycle vectors {inputs, expected status outputs} are queued by helper
// functions and applied in a loop; a small matrix model follows the beats the
// bench expects to be accepted. Reset behaviour is driven by hand.
// Status vector bit order: {o_ready, o_validInput, o_busy, o_frameError,
// o_timeout}, sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_matrix_stream_loader;

  localparam int TIMEOUT = 31;

  localparam logic [4:0] E_LOAD   = 5'b10000;
  localparam logic [4:0] E_LAUNCH = 5'b01100;
  localparam logic [4:0] E_WAIT   = 5'b00100;
  localparam logic [4:0] E_FERR   = 5'b10010;
  localparam logic [4:0] E_TO     = 5'b10001;

  typedef struct {
    logic       valid;
    logic       last;
    logic [7:0] data;
    logic       vres;
    logic [4:0] exp;
    bit         chk_mat;
    string      tag;
  } vec_t;

  logic clk;
  logic rst;
  logic vres;
  logic [3:0][3:0][7:0] o_a, o_b;
  logic o_validInput, o_busy, o_frameError, o_timeout;

  matrix_stream_loader_if #(.DATA_W(8)) bus ();

  matrix_stream_loader #(.DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
    .i_clk         (clk),
    .i_arst        (rst),
    .stream        (bus),
    .o_a           (o_a),
    .o_b           (o_b),
    .o_validInput  (o_validInput),
    .i_validResult (vres),
    .o_busy        (o_busy),
    .o_frameError  (o_frameError),
    .o_timeout     (o_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  vec_t vecs[$];
  logic [3:0][3:0][7:0] model_a, model_b;
  int   idx;
  logic exp_ready_prev;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(logic valid, logic last, logic [7:0] data, logic r,
                              logic [4:0] exp, bit chk, string tag);
    vec_t v;
    v.valid = valid; v.last = last; v.data = data; v.vres = r;
    v.exp = exp; v.chk_mat = chk; v.tag = tag;
    vecs.push_back(v);
  endfunction

  // Frame of nbeats elements (data = base+k) starting at element count 0;
  // i_last on beat last_at (-1: never). gaps inserts idle cycles carrying
  // junk last/data with i_valid low.
  function automatic void add_frame(int base, int last_at, int nbeats, bit gaps, string tag);
    for (int k = 0; k < nbeats; k++) begin
      logic       lst;
      logic [4:0] e;
      int         ng;
      lst = (k == last_at);
      ng  = gaps ? int'($urandom_range(2, 0)) : 0;
      for (int g = 0; g < ng; g++)
        add(1'b0, 1'($urandom_range(1, 0)), 8'($urandom), 1'b0, E_LOAD, 1'b0, {tag, "_gap"});
      if (k == 31 && lst)      e = E_LAUNCH;
      else if (k == 31 || lst) e = E_FERR;
      else                     e = E_LOAD;
      add(1'b1, lst, 8'(base + k), 1'b0, e, 1'b0, tag);
    end
  endfunction

  // Follows a launch: LAUNCH cycle, then WAIT cycles 1..; result driven in
  // WAIT cycle res_at (0: never). junk drives ignored beats meanwhile and
  // raises i_validResult during LAUNCH, where it must be ignored.
  function automatic void add_wait(int res_at, bit junk, string tag);
    add(junk, junk, 8'hEE, junk, E_WAIT, 1'b1, {tag, "_launch"});
    for (int n = 1; n <= TIMEOUT; n++) begin
      if (n == res_at) begin
        add(junk, 1'b0, 8'hEE, 1'b1, E_LOAD, 1'b1, {tag, "_result"});
        return;
      end else if (n == TIMEOUT) begin
        add(junk, 1'b0, 8'hEE, 1'b0, E_TO, 1'b1, {tag, "_timeout"});
      end else begin
        add(junk, 1'b0, 8'hEE, 1'b0, E_WAIT, 1'b0, {tag, "_wait"});
      end
    end
  endfunction

  task automatic apply(input vec_t v, input int i);
    bit beat;
    beat = v.valid && exp_ready_prev;
    bus.i_valid = v.valid;
    bus.i_last  = v.last;
    bus.i_data  = v.data;
    vres        = v.vres;
    @(posedge clk);
    #1;
    if (beat) begin
      if (idx < 16) model_a[idx / 4][idx % 4] = v.data;
      else          model_b[(idx - 16) / 4][(idx - 16) % 4] = v.data;
      idx = (v.exp[3] || v.exp[1]) ? 0 : idx + 1;
    end
    check($sformatf("%s[%0d]_status", v.tag, i),
          128'({bus.o_ready, o_validInput, o_busy, o_frameError, o_timeout}), 128'(v.exp));
    exp_ready_prev = v.exp[4];
    if (v.chk_mat) begin
      check($sformatf("%s[%0d]_a", v.tag, i), o_a, model_a);
      check($sformatf("%s[%0d]_b", v.tag, i), o_b, model_b);
    end
  endtask

  task automatic run_vecs();
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);
    vecs.delete();
  endtask

  initial begin
    rst         = 1'b1;
    vres        = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
    bus.i_data  = '0;
    model_a     = '0;
    model_b     = '0;
    idx         = 0;
    exp_ready_prev = 1'b1;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("reset_status",
          128'({bus.o_ready, o_validInput, o_busy, o_frameError, o_timeout}), 128'(E_LOAD));
    check("reset_a", o_a, 128'd0);
    check("reset_b", o_b, 128'd0);
    rst = 1'b0;

    // Good frame (data k+1), result on WAIT cycle 12.
    add_frame(1, 31, 32, 1'b0, "good1");
    add_wait(12, 1'b0, "hs1");
    add(1'b0, 1'b0, 8'h00, 1'b1, E_LOAD, 1'b0, "idle_vres");
    run_vecs();
    check("good1_a00", 128'(o_a[0][0]), 128'd1);
    check("good1_a33", 128'(o_a[3][3]), 128'd16);
    check("good1_b00", 128'(o_b[0][0]), 128'd17);
    check("good1_b33", 128'(o_b[3][3]), 128'd32);

    // Fresh frame under backpressure; junk beats during WAIT; timeout.
    add_frame(101, 31, 32, 1'b1, "bp2");
    add_wait(0, 1'b1, "to2");
    add(1'b0, 1'b0, 8'h00, 1'b0, E_LOAD, 1'b1, "after_to");
    run_vecs();

    // Early i_last, then a good frame with result/timeout coincidence.
    add_frame(50, 9, 10, 1'b0, "early");
    add(1'b0, 1'b0, 8'h00, 1'b0, E_LOAD, 1'b0, "after_early");
    add_frame(200, 31, 32, 1'b1, "good3");
    add_wait(TIMEOUT, 1'b1, "coinc");
    add(1'b0, 1'b0, 8'h00, 1'b0, E_LOAD, 1'b0, "after_coinc");

    // Missing i_last, then a good frame.
    add_frame(60, -1, 32, 1'b0, "nolast");
    add(1'b0, 1'b0, 8'h00, 1'b0, E_LOAD, 1'b0, "after_nolast");
    add_frame(7, 31, 32, 1'b0, "good4");
    add_wait(5, 1'b0, "hs4");
    run_vecs();

    // Reset asserted during beat 20 of a frame.
    add_frame(90, 31, 20, 1'b0, "pre_rst");
    run_vecs();
    bus.i_valid = 1'b1;
    bus.i_last  = 1'b0;
    bus.i_data  = 8'd110;
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_status",
          128'({bus.o_ready, o_validInput, o_busy, o_frameError, o_timeout}), 128'(E_LOAD));
    check("rst_mid_a", o_a, 128'd0);
    check("rst_mid_b", o_b, 128'd0);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    bus.i_valid = 1'b0;
    model_a     = '0;
    model_b     = '0;
    idx         = 0;
    exp_ready_prev = 1'b1;

    // Full frame after reset must launch on its 32nd beat.
    add_frame(30, 31, 32, 1'b1, "post_rst");
    add_wait(3, 1'b0, "post_rst_hs");
    run_vecs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/matrix_stream_loader.md
Name: matrix_stream_loader

Overview:
- Upstream feeder for the 4x4 systolic-array top.
- Accepts a byte-wide valid/ready element stream and assembles one 4x4 A matrix and one 4x4 B matrix.
- Presents both matrices to the array with a single-cycle launch strobe, then blocks further input until the array reports a valid result or a timeout expires.
- Guarantees that a launch strobe never lands while a computation is in flight.

Parameters:
- DATA_W, 8, element width; must match the array's 8-bit operand width.
- TIMEOUT, 31, maximum WAIT cycles to hold for i_validResult before abandoning the operation; legal range 13..255.

Ports:
- i_clk  input  1  clock.
- i_arst  input  1  asynchronous reset, active-high.
- i_data  input  DATA_W  stream element.
- i_valid  input  1  stream element valid.
- i_last  input  1  marks the final (32nd) element of a frame; only meaningful with i_valid.
- o_ready  output  1  loader can accept an element this cycle.
- o_a  output  [3:0][3:0][DATA_W-1:0]  assembled A matrix, indexed [row][col].
- o_b  output  [3:0][3:0][DATA_W-1:0]  assembled B matrix, indexed [row][col].
- o_validInput  output  1  one-cycle launch strobe to the array.
- i_validResult  input  1  array result-valid pulse.
- o_busy  output  1  high in LAUNCH and WAIT.
- o_frameError  output  1  one-cycle pulse on a framing error.
- o_timeout  output  1  one-cycle pulse when a wait is abandoned.

Behaviour:
- Beat = i_valid & o_ready. All outputs are registered.
- Reset values: o_a=0, o_b=0, o_validInput=0, o_frameError=0, o_timeout=0, o_busy=0, o_ready=1. State resets to LOAD with element count 0.
- Element order within a frame is row-major A, then row-major B:
  - beat k (0..15) writes a[k/4][k%4];
  - beat k (16..31) writes b[(k-16)/4][(k-16)%4].
- Each write lands at the clock edge of its beat.
- FSM states: LOAD, LAUNCH, WAIT.
- LOAD:
  - o_ready=1.
  - A 5-bit count increments on each beat.
  - Beat with count==31 and i_last=1 → LAUNCH; count returns to 0.
  - Beat with i_last=1 and count!=31 → o_frameError pulses the next cycle; count returns to 0; stay in LOAD.
  - Beat with count==31 and i_last=0 → o_frameError pulses; count returns to 0; no launch; stay in LOAD.
  - After a framing error, matrix contents are don't-care until the next good frame completes.
- LAUNCH:
  - Lasts exactly one cycle: o_validInput=1, o_ready=0, o_busy=1.
  - Latency: 32nd beat accepted at edge t → o_validInput high during cycle t+1.
  - Next state is WAIT.
- WAIT:
  - o_ready=0, o_busy=1.
  - An 8-bit wait counter starts at 0 on entry and increments every cycle.
  - i_validResult=1 → LOAD next cycle; o_ready=1 in that cycle.
  - Otherwise, wait counter == TIMEOUT-1 → o_timeout pulses and state goes to LOAD.
  - If i_validResult and the timeout terminal count coincide, the result wins and o_timeout stays 0.
- o_a and o_b are held stable from LAUNCH until the first beat of the next frame.
- i_validResult outside WAIT is ignored.
- i_data, i_last and i_valid are ignored while o_ready=0; no element is lost or duplicated.
- Reset asserted mid-frame or mid-wait returns all state to reset values immediately. A partial frame is discarded.

Test Plan:
- Good frame:
  - Stimulus: 32 beats with data = k+1, i_last on beat 31, i_valid held high.
  - Required: o_a[0][0]=1, o_a[3][3]=16, o_b[0][0]=17, o_b[3][3]=32.
  - o_validInput high exactly one cycle, on the cycle after beat 31.
  - o_ready low from that cycle on.
- Result handshake:
  - Stimulus: after launch, drive i_validResult on the 12th WAIT cycle.
  - Required: o_busy drops and o_ready=1 on the following cycle.
  - A second frame then loads with fresh values and launches again.
- Early i_last:
  - Stimulus: i_last on beat 9.
  - Required: o_frameError pulses once and no o_validInput.
  - A following good 32-beat frame launches normally.
- Missing i_last:
  - Stimulus: 32 beats without i_last.
  - Required: o_frameError pulses and no launch.
- Timeout:
  - Stimulus: TIMEOUT=31, never assert i_validResult.
  - Required: o_timeout pulses after WAIT cycle 31, then o_ready=1.
  - In the coincidence variant (i_validResult on that same cycle), o_timeout=0.
- Backpressure and reset:
  - Stimulus: toggle i_valid randomly, and drive beats while in WAIT.
  - Required: matrices match the accepted beats only.
  - Asserting i_arst at beat 20 clears the count, o_a, o_b and o_busy. A subsequent full frame loads correctly.
